// File: rtl/jtag_pkg.sv
// Shared definitions for the on-chip JTAG scan master:
// command op codes, FSM states and the TAP reset walk length.
package jtag_pkg;

  typedef enum logic [1:0] {
    OP_DR    = 2'd0,
    OP_IR    = 2'd1,
    OP_RESET = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [3:0] {
    INIT,
    IDLE,
    TLR,
    SEL_DR,
    SEL_IR,
    CAPTURE,
    SHIFT,
    EXIT1,
    UPDATE,
    RTI,
    RESP
  } state_e;

  localparam int TLR_TCKS = 5;

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK generator: CLK_DIV clk low, CLK_DIV clk high per bit,
// with strobes marking the edges of the bit that is about to happen.
module jtag_tck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  output logic tck_o,
  output logic fall_stb_o,
  output logic rise_stb_o,
  output logic bit_done_o
);

  localparam int CW = $clog2(2 * CLK_DIV + 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV);
  localparam logic [CW-1:0] FULL = CW'(2 * CLK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tck_q, tck_d;

  // cnt 0 only marks a fresh start; the end of a high phase is also
  // the start of the next bit.
  assign rise_stb_o = enable_i && (cnt_q == HALF);
  assign bit_done_o = enable_i && (cnt_q == FULL);
  assign fall_stb_o = enable_i && ((cnt_q == '0) || (cnt_q == FULL));
  assign tck_o      = tck_q;

  always_comb begin
    cnt_d = '0;
    tck_d = 1'b0;
    if (enable_i) begin
      cnt_d = fall_stb_o ? CW'(1) : cnt_q + 1'b1;
      if (rise_stb_o)      tck_d = 1'b1;
      else if (fall_stb_o) tck_d = 1'b0;
      else                 tck_d = tck_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

endmodule

// File: rtl/jtag_scan_master.sv
// JTAG master: turns one IR/DR scan or TAP reset command into a
// TMS/TDI walk from Run-Test/Idle back to Run-Test/Idle.
module jtag_scan_master
  import jtag_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int CLK_DIV = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [$clog2(MAX_LEN+1)-1:0] cmd_len,
  input  logic [MAX_LEN-1:0]         cmd_data,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [MAX_LEN-1:0]         resp_data,
  output logic                       resp_err,
  output logic                       busy,
  output logic                       tck,
  output logic                       tms,
  output logic                       tdi,
  input  logic                       tdo
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int BW = (LW > 3) ? LW : 3;
  localparam int IW = $clog2(MAX_LEN);

  state_e             state_q, state_d;
  logic [BW-1:0]      bcnt_q, bcnt_d;
  logic [BW-1:0]      len_q, len_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] cap_q, cap_d;
  logic               ir_q, ir_d;
  logic               err_q, err_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic               en, fall_stb, rise_stb, bit_done;
  logic               bad_cmd;

  assign en = (state_q != IDLE) && (state_q != RESP);
  assign bad_cmd = (cmd_len == '0) || (cmd_len > LW'(MAX_LEN))
                 || (cmd_op == OP_RSVD);

  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck (
    .clk_i      (clk),
    .rst_i      (rst),
    .enable_i   (en),
    .tck_o      (tck),
    .fall_stb_o (fall_stb),
    .rise_stb_o (rise_stb),
    .bit_done_o (bit_done)
  );

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    len_d   = len_q;
    data_d  = data_q;
    cap_d   = cap_q;
    ir_d    = ir_q;
    err_d   = err_q;
    tms_d   = tms_q;
    tdi_d   = tdi_q;
    unique case (state_q)
      INIT, TLR: if (bit_done) begin
        if (bcnt_q == BW'(TLR_TCKS)) begin
          bcnt_d  = '0;
          state_d = (state_q == INIT) ? IDLE : RESP;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      IDLE: if (cmd_valid) begin
        cap_d  = '0;
        err_d  = 1'b0;
        bcnt_d = '0;
        ir_d   = (cmd_op == OP_IR);
        len_d  = BW'(cmd_len);
        data_d = cmd_data;
        if (bad_cmd) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else if (cmd_op == OP_RESET) begin
          state_d = TLR;
        end else begin
          state_d = RTI;
        end
      end
      RTI:     if (bit_done) state_d = SEL_DR;
      SEL_DR:  if (bit_done) state_d = ir_q ? SEL_IR : CAPTURE;
      SEL_IR:  if (bit_done) state_d = CAPTURE;
      CAPTURE: if (bit_done) state_d = SHIFT;
      SHIFT: begin
        if (rise_stb) cap_d[bcnt_q[IW-1:0]] = tdo;
        if (bit_done) begin
          data_d = data_q >> 1;
          if (bcnt_q == len_q - 1'b1) begin
            bcnt_d  = '0;
            state_d = EXIT1;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      EXIT1:   if (bit_done) state_d = UPDATE;
      UPDATE:  if (bit_done) state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = INIT;
    endcase
    // TMS/TDI for the bit that starts at this edge come from the
    // state that bit belongs to.
    if (fall_stb) begin
      tdi_d = 1'b0;
      unique case (state_d)
        INIT, TLR: tms_d = (bcnt_d < BW'(TLR_TCKS));
        RTI:       tms_d = 1'b1;
        SEL_DR:    tms_d = ir_q;
        SHIFT: begin
          tms_d = (bcnt_d == len_q - 1'b1);
          tdi_d = data_d[0];
        end
        EXIT1:     tms_d = 1'b1;
        default:   tms_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      bcnt_q  <= '0;
      len_q   <= '0;
      data_q  <= '0;
      cap_q   <= '0;
      ir_q    <= 1'b0;
      err_q   <= 1'b0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      len_q   <= len_d;
      data_q  <= data_d;
      cap_q   <= cap_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_data  = cap_q;
  assign resp_err   = err_q;
  assign busy       = en;
  assign tms        = tms_q;
  assign tdi        = tdi_q;

endmodule
